mlp_layer_ctrl: RTL and testbench
=================================

MLP_LAYER_CTRL -- requirements
Module: mlp_layer_ctrl

Interface
REQ-001 Parameter NUM_NEURONS, 10, neurons per layer, one MAC pass each.
REQ-002 Parameter FP_TOTAL_BITS, 16, fixed-point word width; matches the MAC.
REQ-003 Parameter TIMEOUT_CYCLES, 16, maximum cycles in MAC_WAIT before error.
REQ-004 Port clk input 1, single clock; all logic on rising edge.
REQ-005 Port reset input 1, asynchronous active-high reset.
REQ-006 Port layer_start input 1, one-cycle request to process a layer; ignored while busy=1.
REQ-007 Port relu_en input 1, sampled with layer_start; 1 clamps negative results to 0.
REQ-008 Port busy output 1, high from the cycle after an accepted layer_start until layer_done.
REQ-009 Port layer_done output 1, one-cycle pulse at layer end.
REQ-010 Port layer_err output 1, valid with layer_done; 1 if a MAC timeout aborted the layer.
REQ-011 Port param_rd_en output 1, one-cycle read strobe to the weight/bias memory.
REQ-012 Port param_addr output $clog2(NUM_NEURONS), neuron index being read.
REQ-013 Port param_rd_valid input 1, memory indicates weights/bias are presented to the MAC.
REQ-014 Port mac_start output 1, one-cycle start pulse to the MAC.
REQ-015 Port mac_done input 1, one-cycle MAC completion pulse; result is valid the following cycle.
REQ-016 Port mac_result input FP_TOTAL_BITS signed, MAC output word.
REQ-017 Port out_we, out_addr ($clog2(NUM_NEURONS)), out_data (FP_TOTAL_BITS signed): outputs, one-cycle write to the activation buffer.

Function
REQ-018 States: IDLE, FETCH, LOAD, RUN, MAC_WAIT, CAPTURE, WRITE.
REQ-019 IDLE + layer_start -> FETCH; latch relu_en; neuron index idx=0; clear the error flag.
REQ-020 FETCH: param_rd_en=1, param_addr=idx for exactly one cycle -> LOAD.
REQ-021 LOAD: hold until param_rd_valid=1, then go to RUN; there is no timeout in this state.
REQ-022 RUN: mac_start=1 for one cycle -> MAC_WAIT; clear the timeout counter.
REQ-023 MAC_WAIT: mac_done=1 -> CAPTURE; otherwise increment the counter; counter reaching TIMEOUT_CYCLES -> set error, pulse layer_done with layer_err=1, go to IDLE, no write.
REQ-024 CAPTURE: register mac_result; apply ReLU if latched relu_en and result is negative (0x0000) -> WRITE.
REQ-025 WRITE: out_we=1, out_addr=idx, out_data=registered value for one cycle.
REQ-026 WRITE with idx<NUM_NEURONS-1: idx++ -> FETCH.
REQ-027 WRITE with idx==NUM_NEURONS-1: pulse layer_done with layer_err=0 in the next cycle, then IDLE; idx does not wrap past the last neuron.
REQ-028 Per-neuron latency with 1-cycle memory and a 3-cycle MAC: FETCH through WRITE = 8 cycles; layer = 8*NUM_NEURONS + 1 cycles.
REQ-029 mac_done outside MAC_WAIT is ignored; layer_start in the same cycle as layer_done is ignored.
REQ-030 param_rd_en, mac_start, out_we and layer_done are never high in the same cycle.

Reset
REQ-031 Reset asynchronously forces IDLE, idx=0, and the timeout counter, error flag and captured data to 0.
REQ-032 While reset is high, all outputs are 0: busy, layer_done, layer_err, param_rd_en, param_addr, mac_start, out_we, out_addr, out_data.
REQ-033 Reset mid-layer aborts with no layer_done; the next layer_start restarts at neuron 0.

Structure
REQ-034 Package mlp_pkg holds the state enum, FP_TOTAL_BITS/FP_FRAC_BITS defaults, and the ReLU function.
REQ-035 There is a single optional sub-module, act_relu (combinational ReLU); the state machine, counters and registers reside in mlp_layer_ctrl.

Verification
REQ-036 Scenario NUM_NEURONS=4, MAC model returns 0x0100,0xFF00,0x0280,0x0000, relu_en=0 -> four writes, addr 0..3 with identical data; layer_done at cycle 33 after start; layer_err=0.
REQ-037 Scenario same data, relu_en=1 -> addr1 written 0x0000; other writes unchanged.
REQ-038 Scenario param_rd_valid delayed 5 cycles for neuron 2 -> mac_start delayed accordingly; no extra param_rd_en; results correct.
REQ-039 Scenario MAC model never asserts done on neuron 1 -> layer_done+layer_err=1 exactly TIMEOUT_CYCLES after the mac_start cycle; only addr0 written; busy drops.
REQ-040 Scenario reset asserted in MAC_WAIT of neuron 2, then layer_start -> all outputs 0 immediately; no layer_done; restart reads addr 0.
REQ-041 Scenario layer_start pulsed while busy, plus a stray mac_done in FETCH -> both ignored; write sequence identical to REQ-036.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and fixed-point defaults for the MLP layer controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mlp_pkg;

   localparam int FP_TOTAL_BITS = 16;
   localparam int FP_FRAC_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      RUN,
      MAC_WAIT,
      CAPTURE,
      WRITE
   } state_t;

   // Rectifier on the default word width: negative values become zero.
   function automatic logic signed [FP_TOTAL_BITS-1:0] relu(
      input logic signed [FP_TOTAL_BITS-1:0] x
   );
      return x[FP_TOTAL_BITS-1] ? '0 : x;
   endfunction

endpackage

// File: rtl/mlp_layer_ctrl_act_relu.sv
// Optional rectifier on a MAC result word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: en enables clamping, din is the raw MAC word, dout the activated word.
module act_relu #(
   parameter int W = 16
) (
   input  logic                en,
   input  logic signed [W-1:0] din,
   output logic signed [W-1:0] dout
);

   assign dout = (en && din[W-1]) ? '0 : din;

endmodule

// File: rtl/mlp_layer_ctrl.sv
// Sequences one MLP layer: per neuron read params, run the MAC, activate, write out.
// Latency: 8 cycles per neuron with 1-cycle memory and 3-cycle MAC; layer_done one cycle after last write.
// Backpressure: stalls in LOAD until param_rd_valid; MAC_WAIT aborts the layer after TIMEOUT_CYCLES.
// Ports: layer_start/relu_en request a layer; busy/layer_done/layer_err report status;
//        param_rd_en/param_addr/param_rd_valid talk to the weight memory; mac_start/mac_done/
//        mac_result talk to the MAC; out_we/out_addr/out_data write the activation buffer.
module mlp_layer_ctrl #(
   parameter int NUM_NEURONS    = 10,
   parameter int FP_TOTAL_BITS  = 16,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   layer_start,
   input  logic                                   relu_en,
   output logic                                   busy,
   output logic                                   layer_done,
   output logic                                   layer_err,
   output logic                                   param_rd_en,
   output logic [$clog2(NUM_NEURONS)-1:0]         param_addr,
   input  logic                                   param_rd_valid,
   output logic                                   mac_start,
   input  logic                                   mac_done,
   input  logic signed [FP_TOTAL_BITS-1:0]        mac_result,
   output logic                                   out_we,
   output logic [$clog2(NUM_NEURONS)-1:0]         out_addr,
   output logic signed [FP_TOTAL_BITS-1:0]        out_data
);

   import mlp_pkg::*;

   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                          state;
   state_t                          state_nxt;
   logic [IDX_W-1:0]                idx;
   logic [CNT_W-1:0]                wait_cnt;
   logic                            relu_q;
   logic                            done_q;
   logic                            timeout_hit;
   logic signed [FP_TOTAL_BITS-1:0] data_q;
   logic signed [FP_TOTAL_BITS-1:0] act_val;

   act_relu #(.W(FP_TOTAL_BITS)) u_act_relu (
      .en   (relu_q),
      .din  (mac_result),
      .dout (act_val)
   );

   // wait_cnt holds the number of MAC_WAIT cycles already spent, so the
   // TIMEOUT_CYCLES-th wait cycle without mac_done aborts the layer; the
   // error pulse is issued in that same cycle so it lands exactly
   // TIMEOUT_CYCLES after mac_start.
   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            // done_q blocks a start coinciding with the completion pulse.
            if (layer_start && !done_q) state_nxt = FETCH;
         end
         FETCH:   state_nxt = LOAD;
         LOAD: begin
            if (param_rd_valid) state_nxt = RUN;
         end
         RUN:     state_nxt = MAC_WAIT;
         MAC_WAIT: begin
            if (mac_done) begin
               state_nxt = CAPTURE;
            end else if (wait_cnt == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         CAPTURE: state_nxt = WRITE;
         WRITE:   state_nxt = (idx == LAST_IDX) ? IDLE : FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         wait_cnt <= '0;
         relu_q   <= 1'b0;
         done_q   <= 1'b0;
         data_q   <= '0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == WRITE) && (idx == LAST_IDX);
         case (state)
            IDLE: begin
               if (layer_start && !done_q) begin
                  relu_q <= relu_en;
                  idx    <= '0;
               end
            end
            RUN:      wait_cnt <= '0;
            MAC_WAIT: begin
               if (!mac_done) wait_cnt <= wait_cnt + CNT_W'(1);
            end
            // The MAC word is valid the cycle after mac_done, i.e. here.
            CAPTURE:  data_q <= act_val;
            WRITE: begin
               if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Address/data buses are gated to zero outside their strobe cycle.
   assign busy        = (state != IDLE) || done_q;
   assign layer_done  = done_q || timeout_hit;
   assign layer_err   = timeout_hit;
   assign param_rd_en = (state == FETCH);
   assign param_addr  = param_rd_en ? idx : '0;
   assign mac_start   = (state == RUN);
   assign out_we      = (state == WRITE);
   assign out_addr    = out_we ? idx : '0;
   assign out_data    = out_we ? data_q : '0;

endmodule

// File: tb/tb_mlp_layer_ctrl.sv
// Directed bench for mlp_layer_ctrl with a 1-cycle memory model and 3-cycle MAC model.
// Latency: n/a (testbench).
// Backpressure: memory model can stretch param_rd_valid; MAC model can hang one neuron.
module tb_mlp_layer_ctrl;

   localparam int N  = 4;
   localparam int TO = 16;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               layer_start = 1'b0;
   logic               relu_en = 1'b0;
   logic               param_rd_valid = 1'b0;
   logic               mac_done = 1'b0;
   logic signed [15:0] mac_result = 16'sh0000;
   logic               busy, layer_done, layer_err, param_rd_en, mac_start, out_we;
   logic [1:0]         param_addr, out_addr;
   logic signed [15:0] out_data;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [15:0] mac_tab [4] = '{16'h0100, 16'hFF00, 16'h0280, 16'h0000};

   mlp_layer_ctrl #(
      .NUM_NEURONS    (N),
      .FP_TOTAL_BITS  (16),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .layer_start    (layer_start),
      .relu_en        (relu_en),
      .busy           (busy),
      .layer_done     (layer_done),
      .layer_err      (layer_err),
      .param_rd_en    (param_rd_en),
      .param_addr     (param_addr),
      .param_rd_valid (param_rd_valid),
      .mac_start      (mac_start),
      .mac_done       (mac_done),
      .mac_result     (mac_result),
      .out_we         (out_we),
      .out_addr       (out_addr),
      .out_data       (out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Memory and MAC models, driven 1 time unit after each rising edge.
   int       mem_wait = 0;
   int       mac_wait = 0;
   int       delay_n2 = 0;
   int       hang_n = -1;
   bit       stray_en = 1'b0;
   logic     res_next = 1'b0;
   logic [1:0] cur_n = 2'd0;

   always @(posedge clk) begin
      #1;
      param_rd_valid = 1'b0;
      mac_done       = 1'b0;
      mac_result     = res_next ? mac_tab[cur_n] : 16'h5A5A;
      res_next       = 1'b0;
      if (mem_wait > 0) begin
         mem_wait--;
         if (mem_wait == 0) param_rd_valid = 1'b1;
      end
      if (mac_wait > 0) begin
         mac_wait--;
         if (mac_wait == 0) begin
            mac_done = 1'b1;
            res_next = 1'b1;
         end
      end
      if (param_rd_en) begin
         cur_n    = param_addr;
         mem_wait = 1 + ((param_addr == 2'd2) ? delay_n2 : 0);
         if (stray_en && param_addr == 2'd1) mac_done = 1'b1;
      end
      if (mac_start && int'(cur_n) != hang_n) mac_wait = 3;
   end

   // Monitor, 2 time units after each rising edge.
   int         rd_n = 0;
   int         done_n = 0;
   int         overlap_n = 0;
   int         last_done_cyc = 0;
   logic       last_err = 1'b0;
   logic [1:0] wr_addr [$];
   logic [15:0] wr_data [$];
   int         wr_cyc [$];
   int         ms_cyc [$];
   logic [1:0] rd_addr [$];

   always @(posedge clk) begin
      #2;
      if (out_we) begin
         wr_addr.push_back(out_addr);
         wr_data.push_back(out_data);
         wr_cyc.push_back(cyc);
      end
      if (param_rd_en) begin
         rd_n++;
         rd_addr.push_back(param_addr);
      end
      if (mac_start) ms_cyc.push_back(cyc);
      if (layer_done) begin
         done_n++;
         last_done_cyc = cyc;
         last_err      = layer_err;
      end
      if (int'(param_rd_en) + int'(mac_start) + int'(out_we) + int'(layer_done) > 1) overlap_n++;
   end

   task automatic clear_mon();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      ms_cyc.delete(); rd_addr.delete();
      rd_n = 0; done_n = 0;
   endtask

   task automatic start_layer(input logic r, output int s);
      @(posedge clk); #1;
      layer_start = 1'b1; relu_en = r; s = cyc;
      @(posedge clk); #1;
      layer_start = 1'b0; relu_en = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      for (int i = 0; i < budget && done_n == 0; i++) begin
         @(posedge clk); #3;
      end
      ok = (done_n > 0);
   endtask

   task automatic test_reset();
      logic [39:0] outs;
      repeat (3) @(posedge clk);
      #2;
      outs = {busy, layer_done, layer_err, param_rd_en, param_addr, mac_start, out_we, out_addr, out_data};
      tests++;
      if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
      reset = 1'b0;
      @(posedge clk); #2;
      tests++;
      if (busy !== 1'b0 || layer_done !== 1'b0) begin
         fails++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, layer_done);
      end
   endtask

   task automatic test_basic();
      int s; bit ok;
      logic [15:0] exp_d [4];
      exp_d = '{16'h0100, 16'hFF00, 16'h0280, 16'h0000};
      clear_mon();
      start_layer(1'b0, s);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", busy); end
      wait_done(80, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL basic_timeout: no layer_done within budget"); end
      tests++;
      if (last_done_cyc !== s + 33) begin fails++; $display("FAIL basic_done_cyc: got %0d want %0d", last_done_cyc - s, 33); end
      tests++;
      if (last_err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b want 0", last_err); end
      tests++;
      if (ms_cyc.size() < 1 || ms_cyc[0] !== s + 3) begin fails++; $display("FAIL basic_first_mac_start: size %0d want start+3", ms_cyc.size()); end
      tests++;
      if (wr_cyc.size() < 1 || wr_cyc[0] !== s + 8) begin fails++; $display("FAIL basic_first_write: size %0d want start+8", wr_cyc.size()); end
      tests++;
      if (wr_data.size() !== 4 || rd_n !== 4) begin fails++; $display("FAIL basic_counts: writes %0d reads %0d want 4 4", wr_data.size(), rd_n); end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= wr_data.size() || wr_addr[i] !== i[1:0] || wr_data[i] !== exp_d[i]) begin
            fails++; $display("FAIL basic_write%0d: got %h want addr %0d data %h", i, (i < wr_data.size()) ? wr_data[i] : 16'hxxxx, i, exp_d[i]);
         end
      end
      @(posedge clk); #2;
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_relu();
      int s; bit ok;
      logic [15:0] exp_d [4];
      exp_d = '{16'h0100, 16'h0000, 16'h0280, 16'h0000};
      clear_mon();
      start_layer(1'b1, s);
      wait_done(80, ok);
      tests++;
      if (!ok || last_err !== 1'b0) begin fails++; $display("FAIL relu_done: ok %0d err %b want 1 0", ok, last_err); end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= wr_data.size() || wr_addr[i] !== i[1:0] || wr_data[i] !== exp_d[i]) begin
            fails++; $display("FAIL relu_write%0d: got %h want %h", i, (i < wr_data.size()) ? wr_data[i] : 16'hxxxx, exp_d[i]);
         end
      end
   endtask

   task automatic test_load_delay();
      int s; bit ok;
      logic [15:0] exp_d [4];
      exp_d = '{16'h0100, 16'hFF00, 16'h0280, 16'h0000};
      clear_mon();
      delay_n2 = 5;
      start_layer(1'b0, s);
      wait_done(80, ok);
      delay_n2 = 0;
      tests++;
      if (ms_cyc.size() < 3 || ms_cyc[2] !== s + 24) begin fails++; $display("FAIL delay_mac_start2: size %0d want start+24", ms_cyc.size()); end
      tests++;
      if (rd_n !== 4) begin fails++; $display("FAIL delay_reads: got %0d want 4", rd_n); end
      tests++;
      if (!ok || last_done_cyc !== s + 38) begin fails++; $display("FAIL delay_done_cyc: got %0d want %0d", last_done_cyc - s, 38); end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= wr_data.size() || wr_addr[i] !== i[1:0] || wr_data[i] !== exp_d[i]) begin
            fails++; $display("FAIL delay_write%0d: got %h want %h", i, (i < wr_data.size()) ? wr_data[i] : 16'hxxxx, exp_d[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int s; bit ok;
      clear_mon();
      hang_n = 1;
      start_layer(1'b0, s);
      wait_done(80, ok);
      tests++;
      if (!ok || ms_cyc.size() < 2 || last_done_cyc !== ms_cyc[1] + TO) begin
         fails++; $display("FAIL timeout_done_cyc: got %0d want %0d", last_done_cyc - s, 11 + TO);
      end
      tests++;
      if (last_err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", last_err); end
      repeat (5) @(posedge clk);
      #3;
      hang_n = -1;
      tests++;
      if (wr_data.size() !== 1 || wr_addr[0] !== 2'd0 || wr_data[0] !== 16'h0100) begin
         fails++; $display("FAIL timeout_writes: got %0d writes want 1 at addr 0", wr_data.size());
      end
      tests++;
      if (busy !== 1'b0 || done_n !== 1) begin fails++; $display("FAIL timeout_idle: busy %b dones %0d want 0 1", busy, done_n); end
   endtask

   task automatic test_reset_mid();
      int s; bit ok;
      logic [39:0] outs;
      clear_mon();
      start_layer(1'b0, s);
      for (int i = 0; i < 60 && ms_cyc.size() < 3; i++) begin
         @(posedge clk); #3;
      end
      tests++;
      if (ms_cyc.size() !== 3) begin fails++; $display("FAIL rstmid_reach: mac_starts %0d want 3", ms_cyc.size()); end
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      outs = {busy, layer_done, layer_err, param_rd_en, param_addr, mac_start, out_we, out_addr, out_data};
      tests++;
      if (outs !== '0) begin fails++; $display("FAIL rstmid_outputs: got %h want 0", outs); end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #3;
      tests++;
      if (done_n !== 0 || wr_data.size() !== 2) begin
         fails++; $display("FAIL rstmid_abort: dones %0d writes %0d want 0 2", done_n, wr_data.size());
      end
      clear_mon();
      start_layer(1'b0, s);
      wait_done(80, ok);
      tests++;
      if (rd_addr.size() < 1 || rd_addr[0] !== 2'd0) begin fails++; $display("FAIL rstmid_restart_addr: reads %0d want first addr 0", rd_addr.size()); end
      tests++;
      if (!ok || last_done_cyc !== s + 33 || wr_data.size() !== 4 || wr_data[3] !== 16'h0000 || wr_data[2] !== 16'h0280) begin
         fails++; $display("FAIL rstmid_rerun: done at %0d writes %0d want 33 4", last_done_cyc - s, wr_data.size());
      end
   endtask

   task automatic test_back_to_back();
      int s;
      logic [15:0] exp_d [4];
      exp_d = '{16'h0100, 16'hFF00, 16'h0280, 16'h0000};
      clear_mon();
      stray_en = 1'b1;
      start_layer(1'b0, s);
      while (cyc < s + 5) begin @(posedge clk); #1; end
      layer_start = 1'b1; relu_en = 1'b1;
      @(posedge clk); #1;
      layer_start = 1'b0; relu_en = 1'b0;
      for (int i = 0; i < 60 && cyc < s + 33; i++) begin @(posedge clk); #1; end
      layer_start = 1'b1; relu_en = 1'b1;
      @(posedge clk); #1;
      layer_start = 1'b0; relu_en = 1'b0;
      stray_en = 1'b0;
      repeat (15) @(posedge clk);
      #3;
      tests++;
      if (done_n !== 1 || last_done_cyc !== s + 33 || last_err !== 1'b0) begin
         fails++; $display("FAIL b2b_done: dones %0d at %0d want 1 at 33", done_n, last_done_cyc - s);
      end
      tests++;
      if (rd_n !== 4 || busy !== 1'b0) begin fails++; $display("FAIL b2b_no_restart: reads %0d busy %b want 4 0", rd_n, busy); end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= wr_data.size() || wr_addr[i] !== i[1:0] || wr_data[i] !== exp_d[i]) begin
            fails++; $display("FAIL b2b_write%0d: got %h want %h", i, (i < wr_data.size()) ? wr_data[i] : 16'hxxxx, exp_d[i]);
         end
      end
   endtask

   task automatic test_exclusive();
      tests++;
      if (overlap_n !== 0) begin fails++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap_n); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_load_delay();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
